csa_seq_adder_ctrl: RTL and testbench

- Multi-cycle controller that adds or subtracts two WIDTH-bit operands by sequencing one 4-bit carry-select adder slice across the word, least-significant nibble first.
- Carry is held in a register between nibbles.
- Valid/ready handshakes on both the input and output sides.
- Sits between an operand producer (register file or test stimulus) and a result consumer. It trades latency for area against a full-width carry-select adder.

---
 rtl/csa_pkg.sv | 16 +
 rtl/csa_seq_adder_ctrl_if.sv | 29 ++
 rtl/csa_slice4.sv | 33 +++
 rtl/csa_seq_adder_ctrl.sv | 121 ++++++++++++
 tb/tb_csa_seq_adder_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the nibble-serial carry-select adder controller.
package csa_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/csa_seq_adder_ctrl_if.sv
// Operand/result handshake bundle between producer, adder controller and consumer.
// valid/ready: a transfer happens on a rising edge where both are high; the
// sender holds its payload and valid steady until that edge.
interface csa_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/csa_slice4.sv
// Combinational 4-bit carry-select slice: two ripple chains (carry-in 0 and 1)
// with the real carry-in picking the result.
module csa_slice4
    import csa_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);
    logic [SLICE_W-1:0] s0;
    logic [SLICE_W-1:0] s1;
    logic               c0;
    logic               c1;

    always_comb begin
        s0 = '0;
        s1 = '0;
        c0 = 1'b0;
        c1 = 1'b1;
        for (int i = 0; i < SLICE_W; i++) begin
            s0[i] = a[i] ^ b[i] ^ c0;
            c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            s1[i] = a[i] ^ b[i] ^ c1;
            c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
    end

    assign s    = cin ? s1 : s0;
    assign cout = cin ? c1 : c0;

endmodule

// File: rtl/csa_seq_adder_ctrl.sv
// Multi-cycle add/subtract controller: one carry-select nibble slice is stepped
// across the operands LSB-first, with the inter-nibble carry kept in a register.
module csa_seq_adder_ctrl
    import csa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    csa_seq_adder_ctrl_if.slave  bus,
    output csa_state_e           state_o
);
    localparam int NSLICE = nslice(WIDTH);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
            $error("csa_seq_adder_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    csa_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               last_nib;

    assign a_nib    = a_q[SLICE_W*idx_q +: SLICE_W];
    assign b_nib    = b_q[SLICE_W*idx_q +: SLICE_W];
    assign last_nib = (idx_q == IDX_W'(NSLICE - 1));

    csa_slice4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        // Subtraction is A + ~B + 1, so B is inverted once here.
                        a_q        <= bus.a;
                        b_q        <= bus.b ^ {WIDTH{bus.sub}};
                        carry_q    <= bus.sub | bus.cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[SLICE_W*idx_q +: SLICE_W] <= slice_s;
                    carry_q <= slice_co;
                    if (last_nib) begin
                        idx_q       <= '0;
                        cout_q      <= slice_co;
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready rises only after the result handshake edge.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_csa_seq_adder_ctrl.sv
// Directed-vector and golden-model bench for the nibble-serial add/sub controller.
module tb_csa_seq_adder_ctrl;
    import csa_pkg::*;

    localparam int W      = 16;
    localparam int NS     = W / 4;
    localparam int NVEC   = 12;
    localparam int NRAND  = 1000;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        int           stall;
    } vec_t;

    logic       clk;
    logic       rst;
    csa_state_e state_o;
    vec_t       vecs[NVEC];
    int         n_checks;
    int         n_fail;

    csa_seq_adder_ctrl_if #(.WIDTH(W)) bus ();

    csa_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_after_reset(input string tag);
        check({tag, ".state"},     32'(state_o), 32'(IDLE));
        check({tag, ".sum"},       32'(bus.sum), 32'h0);
        check({tag, ".cout"},      32'(bus.cout), 32'h0);
        check({tag, ".ovf"},       32'(bus.ovf), 32'h0);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, ".busy"},      32'(bus.busy), 32'h0);
        check({tag, ".in_ready"},  32'(bus.in_ready), 32'h1);
    endtask

    // One full operation: accept, run, optional stall in DONE, result handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf, input int stall,
                          input bit scramble, input string tag);
        int n;
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        check({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n <= 20) begin
            check({tag, ".in_ready_run"}, 32'(bus.in_ready), 32'h0);
            if (scramble) begin
                bus.a        = W'($urandom);
                bus.b        = W'($urandom);
                bus.cin      = 1'($urandom_range(0, 1));
                bus.sub      = 1'($urandom_range(0, 1));
                bus.in_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        if (!bus.out_valid) begin
            check({tag, ".timeout"}, 32'(bus.out_valid), 32'h1);
            return;
        end
        check({tag, ".latency"},  32'(n), 32'(NS + 1));
        check({tag, ".sum"},      32'(bus.sum), 32'(exp_sum));
        check({tag, ".cout"},     32'(bus.cout), 32'(exp_cout));
        check({tag, ".ovf"},      32'(bus.ovf), 32'(exp_ovf));
        check({tag, ".in_ready_done"}, 32'(bus.in_ready), 32'h0);
        check({tag, ".busy_done"}, 32'(bus.busy), 32'h1);
        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            check({tag, ".hold_valid"},    32'(bus.out_valid), 32'h1);
            check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'h0);
            check({tag, ".hold_sum"},      32'(bus.sum), 32'(exp_sum));
            check({tag, ".hold_cout"},     32'(bus.cout), 32'(exp_cout));
            check({tag, ".hold_ovf"},      32'(bus.ovf), 32'(exp_ovf));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".post_valid"},    32'(bus.out_valid), 32'h0);
        check({tag, ".post_in_ready"}, 32'(bus.in_ready), 32'h1);
        check({tag, ".post_state"},    32'(state_o), 32'(IDLE));
        check({tag, ".post_sum"},      32'(bus.sum), 32'(exp_sum));
    endtask

    initial begin
        logic [W-1:0] ra, rb, rbe, rsum;
        logic         rcin, rsub, rci, rcout, rovf;
        logic [W:0]   full;

        n_checks = 0;
        n_fail   = 0;

        //        a         b         cin   sub   sum       cout  ovf   stall
        vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 3};
        vecs[3]  = '{16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 2};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1};
        vecs[7]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0};
        vecs[9]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 0};
        vecs[10] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 2};
        vecs[11] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_after_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf,
                   vecs[i].stall, 1'b0, $sformatf("vec%0d", i));
        end

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        bus.a        = 16'h00FF;
        bus.b        = 16'h0001;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("midrst.run1_state", 32'(state_o), 32'(RUN));
        @(negedge clk);
        check("midrst.run2_state", 32'(state_o), 32'(RUN));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_after_reset("midrst");
        repeat (NS + 2) begin
            @(negedge clk);
            check("midrst.no_valid", 32'(bus.out_valid), 32'h0);
        end
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 0, 1'b0, "after_rst");

        // Golden-model regression with inputs scrambled while busy.
        for (int i = 0; i < NRAND; i++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            rcin  = 1'($urandom_range(0, 1));
            rsub  = 1'($urandom_range(0, 1));
            rbe   = rsub ? ~rb : rb;
            rci   = rsub ? 1'b1 : rcin;
            full  = {1'b0, ra} + {1'b0, rbe} + {{W{1'b0}}, rci};
            rsum  = full[W-1:0];
            rcout = full[W];
            rovf  = (ra[W-1] == rbe[W-1]) && (rsum[W-1] != ra[W-1]);
            run_op(ra, rb, rcin, rsub, rsum, rcout, rovf,
                   $urandom_range(0, 3), 1'b1, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
